setup_engine: RTL and testbench
===============================

SETUP_ENGINE -- requirements
Module: setup_engine

Interface
REQ-001 SHALL have a single clock and a synchronous active-low reset; no other clock domains.
REQ-002 SHALL have port `clk`, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous active-low reset, sampled on rising `clk`.
REQ-004 SHALL have ports `vx1`, `vx2`, `vx3`, input, 9 bits each: unsigned screen-space vertex X.
REQ-005 SHALL have ports `vy1`, `vy2`, `vy3`, input, 8 bits each: unsigned screen-space vertex Y.
REQ-006 SHALL have ports `vz1`, `vz2`, `vz3`, input, 16 bits each: vertex depth, passed through.
REQ-007 SHALL have port `color_in`, input, 8 bits: triangle color, passed through.
REQ-008 SHALL have port `setup_start`, input, 1 bit: request to set up one triangle.
REQ-009 SHALL have port `setup_ready`, output, 1 bit: high only in IDLE.
REQ-010 SHALL have port `setup_done`, output, 1 bit: one-cycle pulse when the triangle is finished or discarded.
REQ-011 SHALL have ports `a1`, `b1`, `a2`, `b2`, `a3`, `b3`, output, signed 10 bits each: edge coefficients.
REQ-012 SHALL have ports `c1`, `c2`, `c3`, output, signed 18 bits each: edge constants.
REQ-013 SHALL have ports `bbxi` and `bbxf`, output, 9 bits each; and `bbyi` and `bbyf`, output, 8 bits each: bounding box, inclusive.
REQ-014 SHALL have ports `z1`, `z2`, `z3`, output, 16 bits each; `color`, output, 8 bits; `inv_area`, output, 32 bits.
REQ-015 SHALL have port `rasterizer_start`, output, 1 bit: one-cycle start pulse to the rasterizer.
REQ-016 SHALL have port `rasterizer_done`, input, 1 bit: one-cycle completion pulse from the rasterizer.

Function
REQ-017 SHALL implement states IDLE, AREA, ORIENT, EDGES, DIV, ISSUE, WAIT.
REQ-018 SHALL, in IDLE when `setup_start` is 1, capture vertices and color and go to AREA; `setup_start` SHALL be ignored in all other states.
REQ-019 SHALL clamp vertex X values above 319 to 319, and vertex Y values above 239 to 239, at capture.
REQ-020 AREA SHALL compute `area2` = (x2-x1)*(y3-y1) - (x3-x1)*(y2-y1) as a signed value of at least 20 bits, then go to ORIENT.
REQ-021 ORIENT, when `area2` = 0, SHALL assert no `rasterizer_start`, pulse `setup_done` on the next cycle, and return to IDLE.
REQ-022 ORIENT, when `area2` < 0, SHALL swap vertex 2 with vertex 3 (x, y and z) and negate `area2`; it SHALL then go to EDGES.
REQ-023 EDGES SHALL compute, in one cycle: a1=y2-y3, b1=x3-x2, c1=x2*y3-x3*y2; a2=y3-y1, b2=x1-x3, c2=x3*y1-x1*y3; a3=y1-y2, b3=x2-x1, c3=x1*y2-x2*y1.
REQ-024 EDGES SHALL set `bbxi`/`bbxf` to the min/max vertex X and `bbyi`/`bbyf` to the min/max vertex Y.
REQ-025 Edge values at each vertex SHALL be non-negative for interior pixels; e1 at v1 SHALL equal `area2`.
REQ-026 DIV SHALL compute `inv_area` = floor(2^24 / `area2`) with a restoring divider, one quotient bit per cycle, for exactly 25 cycles, then go to ISSUE.
REQ-027 ISSUE SHALL drive `rasterizer_start` = 1 for exactly one cycle and go to WAIT.
REQ-028 `rasterizer_start` SHALL rise exactly 29 cycles after the edge that accepted `setup_start` (AREA at 1, ORIENT at 2, EDGES at 3, DIV at 4..28, ISSUE at 29).
REQ-029 WAIT SHALL hold `a*`, `b*`, `c*`, the bounding box, `z*`, `color` and `inv_area` stable until `rasterizer_done` = 1.
REQ-030 On `rasterizer_done`, WAIT SHALL pulse `setup_done` for one cycle and return to IDLE.
REQ-031 `rasterizer_done` SHALL be ignored outside WAIT.
REQ-032 All coefficient outputs SHALL hold their values while in IDLE after completion.
REQ-033 Bit widths SHALL not overflow: |a|≤239, |b|≤319, |c|≤76241, 1≤`area2`≤76241, and `inv_area` ≤ 2^24.

Reset
REQ-034 While `rst` = 0, the block SHALL enter IDLE from any state, including DIV and WAIT, and abandon the triangle.
REQ-035 While `rst` = 0, all outputs SHALL be 0 except `setup_ready` = 1, and `rasterizer_start`/`setup_done` SHALL be 0.
REQ-036 `setup_start` sampled in the same cycle as `rst` = 0 SHALL be dropped.

Verification
REQ-037 Bench SHALL cover: v=(10,10),(20,10),(10,20), z=(1,2,3) -> a=(-10,10,0), b=(-10,0,10), c=(300,-100,-100), bbox x10..20 y10..20, `inv_area`=167772, `rasterizer_start` at cycle 29.
REQ-038 Bench SHALL cover: the same triangle with v2 and v3 exchanged -> outputs identical to REQ-037, including z=(1,2,3).
REQ-039 Bench SHALL cover: collinear triangle (0,0),(5,5),(10,10) -> no `rasterizer_start`, `setup_done` pulse 3 cycles after accept, `setup_ready`=1 next.
REQ-040 Bench SHALL cover: triangle (0,0),(1,0),(0,1) -> `area2`=1, `inv_area`=0x01000000; and vx=400 -> `bbxf`=319.
REQ-041 Bench SHALL cover: `rst`=0 asserted at DIV cycle 10 -> next cycle all outputs 0 and `setup_ready`=1; a later triangle completes normally.
REQ-042 Bench SHALL cover: `setup_start` held high during WAIT with `rasterizer_done` delayed 500 cycles -> outputs stable, no second start, exactly one `setup_done`.

Source files
------------

// File: rtl/setup_engine.sv
// Triangle setup engine: captures a screen-space triangle, orients it counter-clockwise,
// derives edge equations, bounding box and a fixed-point 1/area, then hands off to a rasterizer.
module setup_engine (
  input  logic               clk,
  input  logic               rst,
  input  logic [8:0]         vx1,
  input  logic [8:0]         vx2,
  input  logic [8:0]         vx3,
  input  logic [7:0]         vy1,
  input  logic [7:0]         vy2,
  input  logic [7:0]         vy3,
  input  logic [15:0]        vz1,
  input  logic [15:0]        vz2,
  input  logic [15:0]        vz3,
  input  logic [7:0]         color_in,
  input  logic               setup_start,
  output logic               setup_ready,
  output logic               setup_done,
  output logic signed [9:0]  a1,
  output logic signed [9:0]  b1,
  output logic signed [9:0]  a2,
  output logic signed [9:0]  b2,
  output logic signed [9:0]  a3,
  output logic signed [9:0]  b3,
  output logic signed [17:0] c1,
  output logic signed [17:0] c2,
  output logic signed [17:0] c3,
  output logic [8:0]         bbxi,
  output logic [8:0]         bbxf,
  output logic [7:0]         bbyi,
  output logic [7:0]         bbyf,
  output logic [15:0]        z1,
  output logic [15:0]        z2,
  output logic [15:0]        z3,
  output logic [7:0]         color,
  output logic [31:0]        inv_area,
  output logic               rasterizer_start,
  input  logic               rasterizer_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AREA   = 3'd1,
    ORIENT = 3'd2,
    EDGES  = 3'd3,
    DIV    = 3'd4,
    ISSUE  = 3'd5,
    WAIT   = 3'd6
  } state_e;

  state_e state_q, state_d;

  // Captured (and possibly reordered) vertices
  logic [8:0]  x1_q, x2_q, x3_q, x1_d, x2_d, x3_d;
  logic [7:0]  y1_q, y2_q, y3_q, y1_d, y2_d, y3_d;
  logic [15:0] vz1_q, vz2_q, vz3_q, vz1_d, vz2_d, vz3_d;
  logic [7:0]  col_q, col_d;

  logic signed [19:0] area_q, area_d;
  logic [19:0] rem_q, rem_d;
  logic [23:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  logic [9:0]  a1_q, b1_q, a2_q, b2_q, a3_q, b3_q;
  logic [9:0]  a1_d, b1_d, a2_d, b2_d, a3_d, b3_d;
  logic [17:0] c1_q, c2_q, c3_q, c1_d, c2_d, c3_d;
  logic [8:0]  bbxi_q, bbxf_q, bbxi_d, bbxf_d;
  logic [7:0]  bbyi_q, bbyf_q, bbyi_d, bbyf_d;
  logic [15:0] z1_q, z2_q, z3_q, z1_d, z2_d, z3_d;
  logic [7:0]  ocol_q, ocol_d;
  logic [31:0] inv_q, inv_d;

  function automatic logic [8:0] clamp_x(input logic [8:0] v);
    return (v > 9'd319) ? 9'd319 : v;
  endfunction

  function automatic logic [7:0] clamp_y(input logic [7:0] v);
    return (v > 8'd239) ? 8'd239 : v;
  endfunction

  function automatic logic [8:0] min3x(input logic [8:0] p, input logic [8:0] q, input logic [8:0] r);
    logic [8:0] m;
    m = (p < q) ? p : q;
    return (r < m) ? r : m;
  endfunction

  function automatic logic [8:0] max3x(input logic [8:0] p, input logic [8:0] q, input logic [8:0] r);
    logic [8:0] m;
    m = (p > q) ? p : q;
    return (r > m) ? r : m;
  endfunction

  function automatic logic [7:0] min3y(input logic [7:0] p, input logic [7:0] q, input logic [7:0] r);
    logic [7:0] m;
    m = (p < q) ? p : q;
    return (r < m) ? r : m;
  endfunction

  function automatic logic [7:0] max3y(input logic [7:0] p, input logic [7:0] q, input logic [7:0] r);
    logic [7:0] m;
    m = (p > q) ? p : q;
    return (r > m) ? r : m;
  endfunction

  // Twice the signed triangle area; positive means counter-clockwise in this frame
  logic signed [19:0] sx1, sx2, sx3, sy1, sy2, sy3, area_c;
  assign sx1 = {11'b0, x1_q};
  assign sx2 = {11'b0, x2_q};
  assign sx3 = {11'b0, x3_q};
  assign sy1 = {12'b0, y1_q};
  assign sy2 = {12'b0, y2_q};
  assign sy3 = {12'b0, y3_q};
  assign area_c = (sx2 - sx1) * (sy3 - sy1) - (sx3 - sx1) * (sy2 - sy1);

  logic [16:0] p23, p32, p31, p13, p12, p21;
  assign p23 = 17'(x2_q) * 17'(y3_q);
  assign p32 = 17'(x3_q) * 17'(y2_q);
  assign p31 = 17'(x3_q) * 17'(y1_q);
  assign p13 = 17'(x1_q) * 17'(y3_q);
  assign p12 = 17'(x1_q) * 17'(y2_q);
  assign p21 = 17'(x2_q) * 17'(y1_q);

  // Restoring divider step: dividend 2^24 feeds its single set bit on the first step
  logic [20:0] rem_sh;
  logic [19:0] rem_sub;
  logic        q_bit;
  assign rem_sh  = {rem_q, (cnt_q == 5'd24)};
  assign q_bit   = (rem_sh >= {1'b0, area_q});
  assign rem_sub = rem_sh[19:0] - area_q;

  always_comb begin
    state_d = state_q;
    x1_d = x1_q;  x2_d = x2_q;  x3_d = x3_q;
    y1_d = y1_q;  y2_d = y2_q;  y3_d = y3_q;
    vz1_d = vz1_q; vz2_d = vz2_q; vz3_d = vz3_q;
    col_d  = col_q;
    area_d = area_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    a1_d = a1_q; b1_d = b1_q; a2_d = a2_q; b2_d = b2_q; a3_d = a3_q; b3_d = b3_q;
    c1_d = c1_q; c2_d = c2_q; c3_d = c3_q;
    bbxi_d = bbxi_q; bbxf_d = bbxf_q; bbyi_d = bbyi_q; bbyf_d = bbyf_q;
    z1_d = z1_q; z2_d = z2_q; z3_d = z3_q;
    ocol_d = ocol_q;
    inv_d  = inv_q;

    case (state_q)
      IDLE: begin
        if (setup_start) begin
          x1_d = clamp_x(vx1); x2_d = clamp_x(vx2); x3_d = clamp_x(vx3);
          y1_d = clamp_y(vy1); y2_d = clamp_y(vy2); y3_d = clamp_y(vy3);
          vz1_d = vz1; vz2_d = vz2; vz3_d = vz3;
          col_d = color_in;
          state_d = AREA;
        end
      end
      AREA: begin
        area_d  = area_c;
        state_d = ORIENT;
      end
      ORIENT: begin
        if (area_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          if (area_q[19]) begin
            x2_d = x3_q;   x3_d = x2_q;
            y2_d = y3_q;   y3_d = y2_q;
            vz2_d = vz3_q; vz3_d = vz2_q;
            area_d = -area_q;
          end
          state_d = EDGES;
        end
      end
      EDGES: begin
        a1_d = {2'b0, y2_q} - {2'b0, y3_q};
        b1_d = {1'b0, x3_q} - {1'b0, x2_q};
        c1_d = {1'b0, p23} - {1'b0, p32};
        a2_d = {2'b0, y3_q} - {2'b0, y1_q};
        b2_d = {1'b0, x1_q} - {1'b0, x3_q};
        c2_d = {1'b0, p31} - {1'b0, p13};
        a3_d = {2'b0, y1_q} - {2'b0, y2_q};
        b3_d = {1'b0, x2_q} - {1'b0, x1_q};
        c3_d = {1'b0, p12} - {1'b0, p21};
        bbxi_d = min3x(x1_q, x2_q, x3_q);
        bbxf_d = max3x(x1_q, x2_q, x3_q);
        bbyi_d = min3y(y1_q, y2_q, y3_q);
        bbyf_d = max3y(y1_q, y2_q, y3_q);
        z1_d = vz1_q; z2_d = vz2_q; z3_d = vz3_q;
        ocol_d = col_q;
        rem_d  = '0;
        quot_d = '0;
        cnt_d  = 5'd24;
        state_d = DIV;
      end
      DIV: begin
        rem_d  = q_bit ? rem_sub : rem_sh[19:0];
        quot_d = {quot_q[22:0], q_bit};
        if (cnt_q == 5'd0) begin
          inv_d   = {7'b0, quot_q, q_bit};
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (rasterizer_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      x1_q <= '0; x2_q <= '0; x3_q <= '0;
      y1_q <= '0; y2_q <= '0; y3_q <= '0;
      vz1_q <= '0; vz2_q <= '0; vz3_q <= '0;
      col_q  <= '0;
      area_q <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      a1_q <= '0; b1_q <= '0; a2_q <= '0; b2_q <= '0; a3_q <= '0; b3_q <= '0;
      c1_q <= '0; c2_q <= '0; c3_q <= '0;
      bbxi_q <= '0; bbxf_q <= '0; bbyi_q <= '0; bbyf_q <= '0;
      z1_q <= '0; z2_q <= '0; z3_q <= '0;
      ocol_q <= '0;
      inv_q  <= '0;
    end else begin
      state_q <= state_d;
      x1_q <= x1_d; x2_q <= x2_d; x3_q <= x3_d;
      y1_q <= y1_d; y2_q <= y2_d; y3_q <= y3_d;
      vz1_q <= vz1_d; vz2_q <= vz2_d; vz3_q <= vz3_d;
      col_q  <= col_d;
      area_q <= area_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      a1_q <= a1_d; b1_q <= b1_d; a2_q <= a2_d; b2_q <= b2_d; a3_q <= a3_d; b3_q <= b3_d;
      c1_q <= c1_d; c2_q <= c2_d; c3_q <= c3_d;
      bbxi_q <= bbxi_d; bbxf_q <= bbxf_d; bbyi_q <= bbyi_d; bbyf_q <= bbyf_d;
      z1_q <= z1_d; z2_q <= z2_d; z3_q <= z3_d;
      ocol_q <= ocol_d;
      inv_q  <= inv_d;
    end
  end

  assign setup_ready      = (state_q == IDLE);
  assign rasterizer_start = (state_q == ISSUE);
  assign setup_done       = done_q;

  assign a1 = a1_q;  assign b1 = b1_q;
  assign a2 = a2_q;  assign b2 = b2_q;
  assign a3 = a3_q;  assign b3 = b3_q;
  assign c1 = c1_q;  assign c2 = c2_q;  assign c3 = c3_q;
  assign bbxi = bbxi_q;  assign bbxf = bbxf_q;
  assign bbyi = bbyi_q;  assign bbyf = bbyf_q;
  assign z1 = z1_q;  assign z2 = z2_q;  assign z3 = z3_q;
  assign color    = ocol_q;
  assign inv_area = inv_q;

endmodule

// File: tb/tb_setup_engine.sv
// Bench for setup_engine: directed corner triangles plus random triangles checked
// against an arithmetic reference model of the setup rules.
module tb_setup_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]  vx1, vx2, vx3;
  logic [7:0]  vy1, vy2, vy3;
  logic [15:0] vz1, vz2, vz3;
  logic [7:0]  color_in;
  logic        setup_start, rasterizer_done;
  logic        setup_ready, setup_done, rasterizer_start;
  logic signed [9:0]  a1, b1, a2, b2, a3, b3;
  logic signed [17:0] c1, c2, c3;
  logic [8:0]  bbxi, bbxf;
  logic [7:0]  bbyi, bbyf;
  logic [15:0] z1, z2, z3;
  logic [7:0]  color;
  logic [31:0] inv_area;

  setup_engine dut (
    .clk(clk), .rst(rst),
    .vx1(vx1), .vx2(vx2), .vx3(vx3),
    .vy1(vy1), .vy2(vy2), .vy3(vy3),
    .vz1(vz1), .vz2(vz2), .vz3(vz3),
    .color_in(color_in), .setup_start(setup_start),
    .setup_ready(setup_ready), .setup_done(setup_done),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
    .c1(c1), .c2(c2), .c3(c3),
    .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
    .z1(z1), .z2(z2), .z3(z3), .color(color), .inv_area(inv_area),
    .rasterizer_start(rasterizer_start), .rasterizer_done(rasterizer_done)
  );

  logic [235:0] dut_bundle;
  assign dut_bundle = {a1, b1, a2, b2, a3, b3, c1, c2, c3, bbxi, bbxf, bbyi, bbyf,
                       z1, z2, z3, color, inv_area};

  int n_assert = 0;
  int n_fail   = 0;

  // Reference expectations (held across degenerate triangles, cleared by reset)
  int e_a[3], e_b[3], e_c[3], e_z[3];
  int e_bxi, e_bxf, e_byi, e_byf, e_col, e_inv, e_area, e_x1, e_y1;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [235:0] exp_bundle();
    return {10'(e_a[0]), 10'(e_b[0]), 10'(e_a[1]), 10'(e_b[1]), 10'(e_a[2]), 10'(e_b[2]),
            18'(e_c[0]), 18'(e_c[1]), 18'(e_c[2]), 9'(e_bxi), 9'(e_bxf), 8'(e_byi), 8'(e_byf),
            16'(e_z[0]), 16'(e_z[1]), 16'(e_z[2]), 8'(e_col), 32'(e_inv)};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      e_a[i] = 0; e_b[i] = 0; e_c[i] = 0; e_z[i] = 0;
    end
    e_bxi = 0; e_bxf = 0; e_byi = 0; e_byf = 0; e_col = 0; e_inv = 0;
  endtask

  task automatic model();
    int x[3], y[3], z[3], t, ar, j, k;
    x[0] = (int'(vx1) > 319) ? 319 : int'(vx1);
    x[1] = (int'(vx2) > 319) ? 319 : int'(vx2);
    x[2] = (int'(vx3) > 319) ? 319 : int'(vx3);
    y[0] = (int'(vy1) > 239) ? 239 : int'(vy1);
    y[1] = (int'(vy2) > 239) ? 239 : int'(vy2);
    y[2] = (int'(vy3) > 239) ? 239 : int'(vy3);
    z[0] = int'(vz1); z[1] = int'(vz2); z[2] = int'(vz3);
    ar = (x[1] - x[0]) * (y[2] - y[0]) - (x[2] - x[0]) * (y[1] - y[0]);
    e_area = ar;
    if (ar == 0) return;
    if (ar < 0) begin
      t = x[1]; x[1] = x[2]; x[2] = t;
      t = y[1]; y[1] = y[2]; y[2] = t;
      t = z[1]; z[1] = z[2]; z[2] = t;
      ar = -ar;
    end
    e_area = ar;
    for (int i = 0; i < 3; i++) begin
      j = (i + 1) % 3;
      k = (i + 2) % 3;
      e_a[i] = y[j] - y[k];
      e_b[i] = x[k] - x[j];
      e_c[i] = x[j] * y[k] - x[k] * y[j];
      e_z[i] = z[i];
    end
    e_bxi = x[0]; e_bxf = x[0]; e_byi = y[0]; e_byf = y[0];
    for (int i = 1; i < 3; i++) begin
      if (x[i] < e_bxi) e_bxi = x[i];
      if (x[i] > e_bxf) e_bxf = x[i];
      if (y[i] < e_byi) e_byi = y[i];
      if (y[i] > e_byf) e_byf = y[i];
    end
    e_col = int'(color_in);
    e_inv = (1 << 24) / ar;
    e_x1 = x[0];
    e_y1 = y[0];
  endtask

  task automatic set_tri(input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3, input int zz1, input int zz2,
                         input int zz3, input int col);
    vx1 = 9'(x1); vy1 = 8'(y1); vx2 = 9'(x2); vy2 = 8'(y2); vx3 = 9'(x3); vy3 = 8'(y3);
    vz1 = 16'(zz1); vz2 = 16'(zz2); vz3 = 16'(zz3); color_in = 8'(col);
  endtask

  task automatic check_outs(input string p);
    int ev;
    check({p, ".a1"}, a1, e_a[0]);  check({p, ".b1"}, b1, e_b[0]);  check({p, ".c1"}, c1, e_c[0]);
    check({p, ".a2"}, a2, e_a[1]);  check({p, ".b2"}, b2, e_b[1]);  check({p, ".c2"}, c2, e_c[1]);
    check({p, ".a3"}, a3, e_a[2]);  check({p, ".b3"}, b3, e_b[2]);  check({p, ".c3"}, c3, e_c[2]);
    check({p, ".bbxi"}, bbxi, e_bxi); check({p, ".bbxf"}, bbxf, e_bxf);
    check({p, ".bbyi"}, bbyi, e_byi); check({p, ".bbyf"}, bbyf, e_byf);
    check({p, ".z1"}, z1, e_z[0]); check({p, ".z2"}, z2, e_z[1]); check({p, ".z3"}, z3, e_z[2]);
    check({p, ".color"}, color, e_col);
    check({p, ".inv_area"}, inv_area, e_inv);
    ev = int'(a1) * e_x1 + int'(b1) * e_y1 + int'(c1);
    check({p, ".e1_at_v1"}, ev, e_area);
  endtask

  // Issue one triangle; dly = cycles the rasterizer stays busy, hold keeps setup_start high
  task automatic run_tri(input string nm, input int dly, input bit hold);
    int cyc, st_cyc, n_st, n_done, done_cyc;
    bit stable;
    @(negedge clk);
    check({nm, ".ready_pre"}, setup_ready, 1);
    model();
    setup_start = 1'b1;
    @(posedge clk);
    cyc = 0; st_cyc = -1; n_st = 0; n_done = 0; done_cyc = -1;
    if (e_area == 0) begin
      repeat (6) begin
        @(negedge clk);
        cyc++;
        setup_start = 1'b0;
        if (rasterizer_start) n_st++;
        if (setup_done) begin
          n_done++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (cyc == 4) check({nm, ".coll_ready"}, setup_ready, 1);
      end
      check({nm, ".coll_starts"}, n_st, 0);
      check({nm, ".coll_done_cyc"}, done_cyc, 3);
      check({nm, ".coll_n_done"}, n_done, 1);
      check({nm, ".coll_hold"}, (dut_bundle === exp_bundle()), 1);
      return;
    end
    while (st_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!hold) setup_start = 1'b0;
      rasterizer_done = (cyc == 10);
      if (rasterizer_start) st_cyc = cyc;
      if (setup_done) n_done++;
    end
    check({nm, ".start_cycle"}, st_cyc, 29);
    check_outs({nm, ".issue"});
    stable = 1'b1;
    repeat (dly) begin
      @(negedge clk);
      if (rasterizer_start) n_st++;
      if (setup_done) n_done++;
      if (setup_ready) stable = 1'b0;
      if (dut_bundle !== exp_bundle()) stable = 1'b0;
    end
    check({nm, ".wait_stable"}, stable, 1);
    check({nm, ".extra_start"}, n_st, 0);
    @(negedge clk);
    if (rasterizer_start) n_st++;
    rasterizer_done = 1'b1;
    setup_start = 1'b0;
    @(negedge clk);
    rasterizer_done = 1'b0;
    check({nm, ".done_pulse"}, setup_done, 1);
    check({nm, ".ready_post"}, setup_ready, 1);
    if (setup_done) n_done++;
    @(negedge clk);
    if (setup_done) n_done++;
    if (rasterizer_start) n_st++;
    check({nm, ".n_done"}, n_done, 1);
    check({nm, ".n_extra_start"}, n_st, 0);
    check({nm, ".idle_hold"}, (dut_bundle === exp_bundle()), 1);
  endtask

  task automatic reset_mid_div();
    int n_st;
    set_tri(30, 40, 100, 50, 60, 120, 7, 8, 9, 33);
    @(negedge clk);
    setup_start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      setup_start = 1'b0;
    end
    check("rstdiv.busy", setup_ready, 0);
    rst = 1'b0;
    setup_start = 1'b1;
    @(negedge clk);
    clear_model();
    check("rstdiv.outs_zero", (dut_bundle === '0), 1);
    check("rstdiv.ready", setup_ready, 1);
    check("rstdiv.start", rasterizer_start, 0);
    check("rstdiv.done", setup_done, 0);
    rst = 1'b1;
    setup_start = 1'b0;
    n_st = 0;
    repeat (35) begin
      @(negedge clk);
      if (rasterizer_start) n_st++;
    end
    check("rstdiv.start_dropped", n_st, 0);
    check("rstdiv.ready_after", setup_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    setup_start = 1'b0;
    rasterizer_done = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_model();
    e_area = 0; e_x1 = 0; e_y1 = 0;
    repeat (3) @(negedge clk);
    check("reset.outs_zero", (dut_bundle === '0), 1);
    check("reset.ready", setup_ready, 1);
    check("reset.start", rasterizer_start, 0);
    check("reset.done", setup_done, 0);
    rst = 1'b1;

    set_tri(10, 10, 20, 10, 10, 20, 1, 2, 3, 8'h5A);
    run_tri("ccw", 3, 1'b0);
    check("ccw.a1_const", a1, -10);
    check("ccw.b1_const", b1, -10);
    check("ccw.c1_const", c1, 300);
    check("ccw.a2_const", a2, 10);
    check("ccw.c2_const", c2, -100);
    check("ccw.b3_const", b3, 10);
    check("ccw.c3_const", c3, -100);
    check("ccw.inv_const", inv_area, 167772);
    check("ccw.bbxf_const", bbxf, 20);

    set_tri(10, 10, 10, 20, 20, 10, 1, 3, 2, 8'h5A);
    run_tri("cw", 2, 1'b0);
    check("cw.a1_const", a1, -10);
    check("cw.c1_const", c1, 300);
    check("cw.z2_const", z2, 2);
    check("cw.z3_const", z3, 3);

    set_tri(0, 0, 5, 5, 10, 10, 4, 5, 6, 1);
    run_tri("collinear", 0, 1'b0);

    set_tri(0, 0, 1, 0, 0, 1, 9, 9, 9, 2);
    run_tri("unit", 1, 1'b0);
    check("unit.inv_const", inv_area, 32'h0100_0000);

    set_tri(0, 0, 400, 0, 0, 100, 11, 12, 13, 3);
    run_tri("clampx", 1, 1'b0);
    check("clampx.bbxf_const", bbxf, 319);

    reset_mid_div();
    set_tri(50, 60, 70, 200, 300, 90, 100, 200, 300, 8'hC3);
    run_tri("post_reset", 2, 1'b0);

    set_tri(5, 5, 250, 30, 40, 230, 21, 22, 23, 8'h11);
    run_tri("hold_wait", 500, 1'b1);

    for (int i = 0; i < 20; i++) begin
      set_tri($urandom_range(0, 340), $urandom_range(0, 255), $urandom_range(0, 340),
              $urandom_range(0, 255), $urandom_range(0, 340), $urandom_range(0, 255),
              $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
              $urandom_range(0, 255));
      run_tri($sformatf("rnd%0d", i), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
